// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register with load-use hazard detection, bubble
//            insertion, flush squashing and saturating stall/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_RegDst,
  input  logic              id_ALUSrc,
  input  logic              id_MemtoReg,
  input  logic              id_RegWrite,
  input  logic              id_MemRead,
  input  logic              id_MemWrite,
  input  logic              id_Branch,
  input  logic              id_Jump,
  input  logic              id_BneDst,
  input  logic              id_ExtndDst,
  input  logic [1:0]        id_ALUOp,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              flush,
  output logic              ex_RegDst,
  output logic              ex_ALUSrc,
  output logic              ex_MemtoReg,
  output logic              ex_RegWrite,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_Branch,
  output logic              ex_Jump,
  output logic              ex_BneDst,
  output logic              ex_ExtndDst,
  output logic [1:0]        ex_ALUOp,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic              ex_valid,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic w_uses_rs;
  logic w_uses_rt;
  logic w_rs_hit;
  logic w_rt_hit;
  logic w_bubble;

  // Which source registers the ID instruction actually reads
  assign w_uses_rs = ~id_Jump;
  assign w_uses_rt = id_MemWrite | id_Branch | (id_RegWrite & id_RegDst);
  assign w_rs_hit  = w_uses_rs & (ex_rt == id_rs);
  assign w_rt_hit  = w_uses_rt & (ex_rt == id_rt);

  // Load in EX whose destination is consumed by ID; a flush masks it
  assign stall = ex_valid & ex_MemRead & (ex_rt != 5'd0) & id_valid & ~flush
               & (w_rs_hit | w_rt_hit);

  // Flush, stall or an empty ID slot all inject a bubble into EX
  assign w_bubble = flush | stall | ~id_valid;

  // Pipeline register: datapath always loads, control is zeroed on a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_RegDst   <= 1'b0;
      ex_ALUSrc   <= 1'b0;
      ex_MemtoReg <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_Branch   <= 1'b0;
      ex_Jump     <= 1'b0;
      ex_BneDst   <= 1'b0;
      ex_ExtndDst <= 1'b0;
      ex_ALUOp    <= 2'b00;
      ex_pc4      <= '0;
      ex_rd1      <= '0;
      ex_rd2      <= '0;
      ex_imm      <= '0;
      ex_rs       <= 5'd0;
      ex_rt       <= 5'd0;
      ex_rd       <= 5'd0;
      ex_valid    <= 1'b0;
    end else begin
      ex_pc4 <= id_pc4;
      ex_rd1 <= id_rd1;
      ex_rd2 <= id_rd2;
      ex_imm <= id_imm;
      ex_rs  <= id_rs;
      ex_rt  <= id_rt;
      ex_rd  <= id_rd;
      if (w_bubble) begin
        ex_RegDst   <= 1'b0;
        ex_ALUSrc   <= 1'b0;
        ex_MemtoReg <= 1'b0;
        ex_RegWrite <= 1'b0;
        ex_MemRead  <= 1'b0;
        ex_MemWrite <= 1'b0;
        ex_Branch   <= 1'b0;
        ex_Jump     <= 1'b0;
        ex_BneDst   <= 1'b0;
        ex_ExtndDst <= 1'b0;
        ex_ALUOp    <= 2'b00;
        ex_valid    <= 1'b0;
      end else begin
        ex_RegDst   <= id_RegDst;
        ex_ALUSrc   <= id_ALUSrc;
        ex_MemtoReg <= id_MemtoReg;
        ex_RegWrite <= id_RegWrite;
        ex_MemRead  <= id_MemRead;
        ex_MemWrite <= id_MemWrite;
        ex_Branch   <= id_Branch;
        ex_Jump     <= id_Jump;
        ex_BneDst   <= id_BneDst;
        ex_ExtndDst <= id_ExtndDst;
        ex_ALUOp    <= id_ALUOp;
        ex_valid    <= 1'b1;
      end
    end
  end

  // Saturating event counters; they hold at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + c_cnt_one;
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + c_cnt_one;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Brief    : Self-checking bench for id_ex_stage: directed hazard scenarios
//            followed by randomized traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int CW = 4;

  // control vector bit positions
  localparam int B_REGDST = 9, B_REGWRITE = 6, B_MEMREAD = 5, B_MEMWRITE = 4,
                 B_BRANCH = 3, B_JUMP = 2;
  localparam logic [9:0] RTYPE = 10'b1001000000;
  localparam logic [9:0] LW    = 10'b0111100000;
  localparam logic [9:0] ORI   = 10'b0101000001;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [9:0]    id_ctrl;
  logic [1:0]    id_ALUOp;
  logic [DW-1:0] id_pc4, id_rd1, id_rd2, id_imm;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic          flush;

  logic          ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead;
  logic          ex_MemWrite, ex_Branch, ex_Jump, ex_BneDst, ex_ExtndDst;
  logic [1:0]    ex_ALUOp;
  logic [DW-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]    ex_rs, ex_rt, ex_rd;
  logic          ex_valid, stall;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [9:0]    dut_ctrl;

  assign dut_ctrl = {ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead,
                     ex_MemWrite, ex_Branch, ex_Jump, ex_BneDst, ex_ExtndDst};

  id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_RegDst(id_ctrl[9]), .id_ALUSrc(id_ctrl[8]), .id_MemtoReg(id_ctrl[7]),
    .id_RegWrite(id_ctrl[6]), .id_MemRead(id_ctrl[5]), .id_MemWrite(id_ctrl[4]),
    .id_Branch(id_ctrl[3]), .id_Jump(id_ctrl[2]), .id_BneDst(id_ctrl[1]),
    .id_ExtndDst(id_ctrl[0]), .id_ALUOp(id_ALUOp),
    .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
    .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc), .ex_MemtoReg(ex_MemtoReg),
    .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .ex_Branch(ex_Branch), .ex_Jump(ex_Jump), .ex_BneDst(ex_BneDst),
    .ex_ExtndDst(ex_ExtndDst), .ex_ALUOp(ex_ALUOp),
    .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_valid(ex_valid),
    .stall(stall), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic seen_stall;

  // reference model of the EX slot and the event counters
  logic          m_valid;
  logic [9:0]    m_ctrl;
  logic [1:0]    m_aluop;
  logic [DW-1:0] m_pc4, m_rd1, m_rd2, m_imm;
  logic [4:0]    m_rs, m_rt, m_rd;
  int            m_stall_cnt, m_flush_cnt;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // A load sitting in EX blocks any ID instruction that reads its target
  function automatic logic model_stall();
    logic reads_rs, reads_rt;
    reads_rs = !id_ctrl[B_JUMP];
    reads_rt = id_ctrl[B_MEMWRITE] || id_ctrl[B_BRANCH] ||
               (id_ctrl[B_REGWRITE] && id_ctrl[B_REGDST]);
    return m_valid && m_ctrl[B_MEMREAD] && (m_rt != 0) && id_valid && !flush &&
           ((reads_rs && m_rt == id_rs) || (reads_rt && m_rt == id_rt));
  endfunction

  task automatic model_edge(input logic es);
    if (rst) begin
      m_valid = 0; m_ctrl = '0; m_aluop = '0;
      m_pc4 = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
      m_rs = '0; m_rt = '0; m_rd = '0;
      m_stall_cnt = 0; m_flush_cnt = 0;
    end else begin
      m_pc4 = id_pc4; m_rd1 = id_rd1; m_rd2 = id_rd2; m_imm = id_imm;
      m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
      if (flush || es || !id_valid) begin
        m_ctrl = '0; m_aluop = '0; m_valid = 0;
      end else begin
        m_ctrl = id_ctrl; m_aluop = id_ALUOp; m_valid = 1;
      end
      if (es && m_stall_cnt < (1 << CW) - 1) m_stall_cnt++;
      if (flush && m_flush_cnt < (1 << CW) - 1) m_flush_cnt++;
    end
  endtask

  // One clock: check stall mid-cycle, advance model, check registered outputs
  task automatic step();
    logic es;
    @(negedge clk);
    es = model_stall();
    seen_stall = stall;
    check("stall", 128'(stall), 128'(es));
    @(posedge clk);
    model_edge(es);
    #1;
    check("ex_valid", 128'(ex_valid), 128'(m_valid));
    check("ex_ctrl", 128'({ex_ALUOp, dut_ctrl}), 128'({m_aluop, m_ctrl}));
    check("ex_data", {ex_pc4, ex_rd1, ex_rd2, ex_imm}, {m_pc4, m_rd1, m_rd2, m_imm});
    check("ex_spec", 128'({ex_rs, ex_rt, ex_rd}), 128'({m_rs, m_rt, m_rd}));
    check("stall_cnt", 128'(stall_cnt), 128'(m_stall_cnt));
    check("flush_cnt", 128'(flush_cnt), 128'(m_flush_cnt));
  endtask

  task automatic set_in(input logic [9:0] c, input logic [1:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd,
                        input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    rst = 0; flush = 0; id_valid = 1;
    id_ctrl = c; id_ALUOp = op; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rd1 = d1; id_rd2 = d2; id_pc4 = $urandom; id_imm = $urandom;
  endtask

  initial begin
    m_stall_cnt = 0; m_flush_cnt = 0; m_valid = 0; m_ctrl = '0; m_rt = '0;
    set_in(RTYPE, 2'b10, 1, 2, 3, 0, 0);
    rst = 1;
    step(); step();
    check("reset_all", 128'({ex_valid, dut_ctrl, ex_ALUOp, ex_rs, ex_rt, ex_rd, stall_cnt, flush_cnt}), 128'(0));
    check("reset_data", {ex_pc4, ex_rd1, ex_rd2, ex_imm}, 128'(0));

    // R-type add
    set_in(RTYPE, 2'b10, 8, 9, 10, 5, 7);
    step();
    check("add_ctrl", 128'({ex_RegDst, ex_RegWrite, ex_ALUOp, ex_rd, ex_valid}),
          128'({1'b1, 1'b1, 2'b10, 5'd10, 1'b1}));
    check("add_data", 128'({ex_rd1, ex_rd2}), 128'({32'd5, 32'd7}));

    // load-use: one stall, bubble, then the consumer loads
    set_in(LW, 2'b00, 3, 9, 0, 1, 2);
    step();
    set_in(RTYPE, 2'b10, 9, 4, 10, 3, 4);
    step();
    check("lu_stall", 128'(seen_stall), 128'(1));
    check("lu_bubble", 128'({ex_RegWrite, ex_valid, stall_cnt}), 128'({1'b0, 1'b0, 4'd1}));
    step();
    check("lu_release", 128'({seen_stall, ex_valid, ex_RegWrite}), 128'({1'b0, 1'b1, 1'b1}));

    // $zero destination and rt not read never stall
    set_in(LW, 2'b00, 3, 0, 0, 1, 2);
    step();
    set_in(RTYPE, 2'b10, 0, 0, 5, 1, 1);
    step();
    check("zero_reg", 128'(seen_stall), 128'(0));
    set_in(LW, 2'b00, 3, 9, 0, 1, 2);
    step();
    set_in(ORI, 2'b11, 3, 9, 0, 1, 1);
    step();
    check("ori_rt", 128'(seen_stall), 128'(0));

    // flush wins over a load-use condition
    set_in(LW, 2'b00, 3, 9, 0, 1, 2);
    step();
    set_in(RTYPE, 2'b10, 9, 9, 10, 1, 1);
    flush = 1;
    step();
    check("flush_pri", 128'({seen_stall, ex_valid, dut_ctrl, ex_ALUOp, stall_cnt, flush_cnt}),
          128'({1'b0, 1'b0, 10'b0, 2'b0, 4'd1, 4'd1}));

    // saturate the stall counter with back-to-back load-use pairs
    for (int i = 0; i < 17; i++) begin
      set_in(LW, 2'b00, 1, 5, 0, 1, 2);
      step();
      set_in(LW, 2'b00, 5, 6, 0, 1, 2);
      step();
      check("b2b_stall", 128'(seen_stall), 128'(1));
    end
    check("sat_cnt", 128'(stall_cnt), 128'(4'hF));

    // reset on a stall cycle discards the pending bubble
    set_in(LW, 2'b00, 1, 7, 0, 1, 2);
    step();
    set_in(RTYPE, 2'b10, 7, 2, 3, 1, 1);
    rst = 1;
    step();
    check("rst_stall", 128'({ex_valid, dut_ctrl, ex_rt, stall_cnt, flush_cnt}), 128'(0));
    rst = 0;
    step();
    check("post_rst", 128'({seen_stall, ex_valid}), 128'({1'b0, 1'b1}));

    // empty slot with unknown decoder outputs
    set_in(RTYPE, 2'b10, 1, 2, 3, 1, 1);
    id_valid = 0; id_ctrl = 'x; id_ALUOp = 'x;
    step();
    check("x_ctrl", 128'({ex_valid, dut_ctrl, ex_ALUOp}), 128'(0));

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      id_valid = ($urandom_range(0, 7) != 0);
      id_ctrl  = 10'($urandom);
      id_ALUOp = 2'($urandom);
      id_rs    = 5'($urandom_range(0, 3));
      id_rt    = 5'($urandom_range(0, 3));
      id_rd    = 5'($urandom);
      id_pc4 = $urandom; id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
